seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous double buffering,
// anti-ghosting blank interval, leading-zero blanking and selectable polarity.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIV_COUNT   = 50000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned HEX_EN      = 1,
  parameter int unsigned SEG_ACT_LOW = 0,
  parameter int unsigned AN_ACT_LOW  = 1
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [4*NUM_DIGITS-1:0]                            digits_in,
  input  logic [NUM_DIGITS-1:0]                              dp_in,
  input  logic                                               load,
  input  logic                                               blank_lz,
  output logic [6:0]                                         seg_out,
  output logic                                               dp_out,
  output logic [NUM_DIGITS-1:0]                              an_out,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx,
  output logic                                               frame_done
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(DIV_COUNT);
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam logic        SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic        AN_INV  = (AN_ACT_LOW != 0);

  logic [CW-1:0]         cnt;
  logic                  tc;
  logic                  wrap;
  logic [DW-1:0]         pend_dig;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic [DW-1:0]         disp_dig;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  zrun;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    if ((HEX_EN == 0) && (code > 4'd9)) pat = 7'b0000000;
    return pat;
  endfunction

  assign tc   = (cnt == CW'(DIV_COUNT - 1));
  assign wrap = tc && (scan_idx == IW'(NUM_DIGITS - 1));

  // Slot divider and scan index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      scan_idx <= '0;
    end else if (tc) begin
      cnt      <= '0;
      scan_idx <= wrap ? '0 : scan_idx + IW'(1);
    end else begin
      cnt      <= cnt + CW'(1);
    end
  end

  // Pending/display double buffer; display only changes on a frame wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_dig   <= '0;
      disp_dp    <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
      end
      if (wrap) begin
        pend_valid <= 1'b0;
        if (load) begin
          disp_dig <= digits_in;
          disp_dp  <= dp_in;
        end else if (pend_valid) begin
          disp_dig <= pend_dig;
          disp_dp  <= pend_dp;
        end
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // Digit select, leading-zero detection and decode for the current slot
  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    an_sel   = '0;
    zrun     = 1'b1;
    lz       = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zrun  = zrun && (disp_dig[4*i +: 4] == 4'd0);
      lz[i] = zrun && (i != 0);
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (scan_idx == IW'(i)) begin
        cur_code  = disp_dig[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_lz    = lz[i];
        an_sel[i] = 1'b1;
      end
    end
    seg_nxt = (blank_lz && cur_lz) ? 7'b0000000 : decode(cur_code);
    an_nxt  = (cnt < CW'(BLANK_CYC)) ? '0 : an_sel;
  end

  // Output registers with polarity applied last
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_out    <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      an_out     <= {NUM_DIGITS{AN_INV}};
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_nxt ^ {7{SEG_INV}};
      dp_out     <= cur_dp ^ SEG_INV;
      an_out     <= an_nxt ^ {NUM_DIGITS{AN_INV}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three builds (default, no-hex, inverted polarity)
// compared every cycle against a time-based behavioural model.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic          clk;
  logic          reset;
  logic [15:0]   digits_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          blank_lz;

  logic [6:0]    seg_o [3];
  logic          dp_o  [3];
  logic [3:0]    an_o  [3];
  logic [1:0]    idx_o [3];
  logic          fd_o  [3];

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(.NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYC(BLANK),
                     .HEX_EN(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg_out(seg_o[0]), .dp_out(dp_o[0]), .an_out(an_o[0]),
    .scan_idx(idx_o[0]), .frame_done(fd_o[0]));

  seg7_scan_driver #(.NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYC(BLANK),
                     .HEX_EN(0), .SEG_ACT_LOW(0), .AN_ACT_LOW(1)) dut_nohex (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg_out(seg_o[1]), .dp_out(dp_o[1]), .an_out(an_o[1]),
    .scan_idx(idx_o[1]), .frame_done(fd_o[1]));

  seg7_scan_driver #(.NUM_DIGITS(N), .DIV_COUNT(DIV), .BLANK_CYC(BLANK),
                     .HEX_EN(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(0)) dut_pol (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg_out(seg_o[2]), .dp_out(dp_o[2]), .an_out(an_o[2]),
    .scan_idx(idx_o[2]), .frame_done(fd_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: slot/phase derived from cycles elapsed since reset
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  bit   cfg_hex  [3] = '{1'b1, 1'b0, 1'b1};
  bit   cfg_sinv [3] = '{1'b0, 1'b0, 1'b1};
  bit   cfg_ainv [3] = '{1'b1, 1'b1, 1'b0};

  int   md [N];
  bit   mdp [N];
  int   mp [N];
  bit   mpp [N];
  bit   mpv;
  int   n;
  bit   seen = 1'b0;
  bit   chk_en = 1'b0;

  logic [6:0] e_seg [3];
  logic       e_dp  [3];
  logic [3:0] e_an  [3];
  logic [1:0] e_idx;
  logic       e_fd;

  always @(posedge clk) begin
    int  slot, ph, code;
    bit  wrap, blanked;
    logic [6:0] pat;
    logic [3:0] oh;
    if (reset) begin
      seen = 1'b1;
      n = 0;
      mpv = 1'b0;
      for (int i = 0; i < N; i++) begin md[i] = 0; mdp[i] = 0; mp[i] = 0; mpp[i] = 0; end
      for (int c = 0; c < 3; c++) begin
        e_seg[c] = cfg_sinv[c] ? 7'h7f : 7'h00;
        e_dp[c]  = cfg_sinv[c];
        e_an[c]  = cfg_ainv[c] ? 4'hf : 4'h0;
      end
      e_idx = 2'd0;
      e_fd  = 1'b0;
    end else if (seen) begin
      slot = (n / DIV) % N;
      ph   = n % DIV;
      wrap = (ph == DIV - 1) && (slot == N - 1);
      blanked = blank_lz && (slot > 0);
      for (int j = slot; j < N; j++) if (md[j] != 0) blanked = 1'b0;
      code = md[slot];
      oh = (ph < BLANK) ? 4'h0 : 4'(1 << slot);
      for (int c = 0; c < 3; c++) begin
        pat = (blanked || (!cfg_hex[c] && code > 9)) ? 7'h00 : tbl[code];
        e_seg[c] = cfg_sinv[c] ? ~pat : pat;
        e_dp[c]  = mdp[slot] ^ cfg_sinv[c];
        e_an[c]  = cfg_ainv[c] ? ~oh : oh;
      end
      e_fd  = wrap;
      e_idx = 2'(((n + 1) / DIV) % N);
      if (wrap) begin
        if (load) begin
          for (int i = 0; i < N; i++) begin md[i] = int'(digits_in[4*i +: 4]); mdp[i] = dp_in[i]; end
        end else if (mpv) begin
          for (int i = 0; i < N; i++) begin md[i] = mp[i]; mdp[i] = mpp[i]; end
        end
        mpv = 1'b0;
      end else if (load) begin
        for (int i = 0; i < N; i++) begin mp[i] = int'(digits_in[4*i +: 4]); mpp[i] = dp_in[i]; end
        mpv = 1'b1;
      end
      n++;
    end
    chk_en = seen;
  end

  // Per-cycle comparison of all three builds against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("seg[%0d]", c), 32'(seg_o[c]), 32'(e_seg[c]));
        check($sformatf("dp[%0d]", c),  32'(dp_o[c]),  32'(e_dp[c]));
        check($sformatf("an[%0d]", c),  32'(an_o[c]),  32'(e_an[c]));
        check($sformatf("idx[%0d]", c), 32'(idx_o[c]), 32'(e_idx));
        check($sformatf("fd[%0d]", c),  32'(fd_o[c]),  32'(e_fd));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] t);
    int k = 0;
    while (an_o[0] !== t && k < 64) begin tick(); k++; end
    check($sformatf("wait_an_%b", t), 32'(an_o[0]), 32'(t));
  endtask

  task automatic wait_fd();
    int k = 0;
    tick();
    while (fd_o[0] !== 1'b1 && k < 64) begin tick(); k++; end
    check("wait_frame_done", 32'(fd_o[0]), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d; dp_in = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int gap;
    logic [15:0] rd;
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; digits_in = '0; dp_in = '0;
    repeat (3) tick();
    check("reset_an", 32'(an_o[0]), 32'hf);
    check("reset_seg", 32'(seg_o[0]), 32'h0);
    reset = 1'b0;

    // Plain digits, one-hot active-low anodes, 16-cycle frame
    do_load(16'h1234, 4'b0000);
    wait_fd(); wait_fd();
    wait_an(4'b1110); check("d0_is_4", 32'(seg_o[0]), 32'(7'b0110011));
    wait_an(4'b1101); check("d1_is_3", 32'(seg_o[0]), 32'(7'b1111001));
    wait_an(4'b1011); check("d2_is_2", 32'(seg_o[0]), 32'(7'b1101101));
    wait_an(4'b0111); check("d3_is_1", 32'(seg_o[0]), 32'(7'b0110000));
    wait_fd();
    gap = 0;
    do begin tick(); gap++; end while (fd_o[0] !== 1'b1 && gap < 64);
    check("frame_period", 32'(gap), 32'd16);

    // Leading-zero blanking and hex digits
    blank_lz = 1'b1;
    do_load(16'h00AF, 4'b0000);
    wait_fd(); wait_fd();
    wait_an(4'b0111); check("lz_d3_blank", 32'(seg_o[0]), 32'h0);
    wait_an(4'b1110); check("hex_F", 32'(seg_o[0]), 32'(7'b1000111));
    check("nohex_F_blank", 32'(seg_o[1]), 32'h0);
    wait_an(4'b1101); check("hex_A", 32'(seg_o[0]), 32'(7'b1110111));

    // All zero: only digit 0 lit, dp survives blanking
    do_load(16'h0000, 4'b0100);
    wait_fd(); wait_fd();
    wait_an(4'b1011); check("d2_seg_blank", 32'(seg_o[0]), 32'h0);
    check("d2_dp", 32'(dp_o[0]), 32'd1);
    wait_an(4'b1110); check("d0_zero", 32'(seg_o[0]), 32'(7'b1111110));

    // Mid-frame loads: last wins, and only at the next frame
    wait_fd();
    repeat (5) tick();
    do_load(16'h5555, 4'b0000);
    tick();
    do_load(16'h9999, 4'b0000);
    wait_an(4'b1101); check("old_frame_kept", 32'(seg_o[0]), 32'h0);
    wait_fd();
    wait_an(4'b1101); check("new_frame_9", 32'(seg_o[0]), 32'(7'b1111011));

    // Load coinciding with the wrap cycle
    wait_fd();
    repeat (15) tick();
    do_load(16'h0007, 4'b0000);
    wait_an(4'b1110); check("wrap_load_7", 32'(seg_o[0]), 32'(7'b1110000));

    // Reset mid-slot drops the pending value
    repeat (2) tick();
    do_load(16'h8888, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_an", 32'(an_o[0]), 32'hf);
    check("rst_seg", 32'(seg_o[0]), 32'h0);
    check("rst_idx", 32'(idx_o[0]), 32'h0);
    wait_fd(); wait_fd();
    wait_an(4'b1110); check("pending_dropped", 32'(seg_o[0]), 32'(7'b1111110));

    // Inverted polarity build
    do_load(16'h8888, 4'b0000);
    wait_fd(); wait_fd();
    wait_an(4'b1110);
    check("pol_seg", 32'(seg_o[2]), 32'h0);
    check("pol_dp", 32'(dp_o[2]), 32'd1);
    check("pol_an", 32'(an_o[2]), 32'(4'b0001));

    // Randomized traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      rd = 16'($urandom);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 0) rd[4*k +: 4] = 4'h0;
      digits_in = rd;
      dp_in     = 4'($urandom);
      blank_lz  = 1'($urandom);
      load      = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; load = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
